mem_burst_responder: RTL and testbench

- Memory-controller-side responder for the dcache memory port: services the cache's line-fill read bursts and single-word write-backs from an internal word array.
- Returns read data as a registered burst on mem_out/mem_valid, announcing burst length on mem_burstlen.
- Used as the synthesizable memory model in cache benches, and as the template for the real SDRAM front-end.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_burst_responder_if.sv | 28 ++
 rtl/mem_burst_ram.sv | 35 +++
 rtl/mem_burst_responder.sv | 168 ++++++++++++++++
 tb/tb_mem_burst_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the dcache memory-port responder.
// No logic. Pure declarations.
// Optional build macro: MEM_WRAP_BURST_EN (critical-word-first read bursts).
package mem_pkg;

  localparam int ADDRBITS      = 32;
  localparam int DATABITS      = 32;
  localparam int CACHEWORDS    = 32;
  localparam int CACHEADDRBITS = $clog2(CACHEWORDS);
  localparam int BURSTLEN_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    WACK  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_burst_responder_if.sv
// Cache-to-memory port: read-burst/write requests in, registered data out.
// Latency and flow control are defined by the responder. The master holds
// or retries while mem_busy is high.
interface mem_burst_responder_if #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32
) ();

  logic [ADDRBITS-1:0] mem_addr;
  logic                mem_rdreq;
  logic                mem_wrreq;
  logic [DATABITS-1:0] mem_datain;
  logic [DATABITS-1:0] mem_out;
  logic [15:0]         mem_burstlen;
  logic                mem_valid;
  logic                mem_busy;

  modport master (
    output mem_addr, mem_rdreq, mem_wrreq, mem_datain,
    input  mem_out, mem_burstlen, mem_valid, mem_busy
  );

  modport slave (
    input  mem_addr, mem_rdreq, mem_wrreq, mem_datain,
    output mem_out, mem_burstlen, mem_valid, mem_busy
  );

endinterface

// File: rtl/mem_burst_ram.sv
// Single-port synchronous word array with a registered, enable-gated read port.
// Latency: read data appears one edge after re; write lands on the same edge.
// No backpressure. A same-edge write and read returns the new data (write-first).
module mem_burst_ram #(
  parameter int DATABITS = 32,
  parameter int AW       = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [AW-1:0]       addr,
  input  logic [DATABITS-1:0] wdata,
  output logic [DATABITS-1:0] rdata
);

  logic [DATABITS-1:0] mem [0:(1<<AW)-1];

  // Write port. The array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port. It holds its value when re is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/mem_burst_responder.sv
// Memory responder: line-fill read bursts and single-word write-backs from a word array.
// Latency: first read word LATENCY edges after the request; write ack one edge after the write.
// No backpressure on output. Requests are ignored while mem_busy is high.
// Build macro MEM_WRAP_BURST_EN: the burst starts at the requested word and wraps within the line.
module mem_burst_responder #(
  parameter int ADDRBITS      = mem_pkg::ADDRBITS,
  parameter int DATABITS      = mem_pkg::DATABITS,
  parameter int MEMWORDS_LOG2 = 10,
  parameter int BURSTLEN      = mem_pkg::CACHEWORDS,
  parameter int LATENCY       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_burst_responder_if.slave bus
);

  import mem_pkg::*;

  localparam int OFFW = $clog2(BURSTLEN);
  localparam int LATW = 4;
  localparam logic [LATW-1:0]       LAT_INIT      = LATW'(LATENCY - 1);
  localparam logic [OFFW-1:0]       LAST_BEAT     = OFFW'(BURSTLEN - 1);
  localparam logic [BURSTLEN_W-1:0] BURST_LEN_VAL = BURSTLEN_W'(BURSTLEN);
  localparam logic [BURSTLEN_W-1:0] WACK_LEN_VAL  = BURSTLEN_W'(1);

  mem_state_t               state;
  logic [LATW-1:0]          lat_cnt;
  logic [OFFW-1:0]          beat;
  logic [MEMWORDS_LOG2-1:0] req_idx;
  logic [MEMWORDS_LOG2-1:0] bus_idx;
  logic [MEMWORDS_LOG2-1:0] ram_addr;
  logic [MEMWORDS_LOG2-1:0] burst_addr;
  logic [OFFW-1:0]          line_off;
  logic                     ram_we;
  logic                     ram_re;
  logic [DATABITS-1:0]      ram_rdata;
  logic                     valid_q;
  logic                     busy_q;
  logic [BURSTLEN_W-1:0]    burstlen_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[ADDRBITS-1:MEMWORDS_LOG2+2], bus.mem_addr[1:0]};

  assign bus_idx = bus.mem_addr[MEMWORDS_LOG2+1:2];

  // A write is committed on the accept edge itself. A simultaneous read wins and drops it.
  assign ram_we = (state == IDLE) && bus.mem_wrreq && !bus.mem_rdreq;

`ifdef MEM_WRAP_BURST_EN
  // Critical word first: the offset starts at the requested word and wraps inside the line.
  assign line_off = req_idx[OFFW-1:0] + beat;
`else
  // Line-aligned: the requested word's position within the line is irrelevant.
  assign line_off = beat;
  logic unused_line_bits;
  assign unused_line_bits = ^req_idx[OFFW-1:0];
`endif

  // The line base is aligned, so concatenation gives the modulo-array address.
  assign burst_addr = {req_idx[MEMWORDS_LOG2-1:OFFW], line_off};

  // RAM port steering. In IDLE the live index is used for writes. Otherwise the latched request is used.
  always_comb begin
    ram_addr = bus_idx;
    ram_re   = 1'b0;
    unique case (state)
      IDLE: begin
        ram_addr = bus_idx;
      end
      WAIT: begin
        ram_addr = burst_addr;
        ram_re   = (lat_cnt == '0);
      end
      BURST: begin
        ram_addr = burst_addr;
        ram_re   = 1'b1;
      end
      WACK: begin
        ram_addr = req_idx;
        ram_re   = 1'b1;
      end
      default: begin
        ram_addr = bus_idx;
        ram_re   = 1'b0;
      end
    endcase
  end

  // Control FSM with latency/beat counters. The valid, burst length and busy flags are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      beat       <= '0;
      req_idx    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      burstlen_q <= '0;
    end else begin
      valid_q    <= 1'b0;
      burstlen_q <= '0;
      unique case (state)
        IDLE: begin
          if (bus.mem_rdreq) begin
            state   <= WAIT;
            req_idx <= bus_idx;
            lat_cnt <= LAT_INIT;
            beat    <= '0;
            busy_q  <= 1'b1;
          end else if (bus.mem_wrreq) begin
            state   <= WACK;
            req_idx <= bus_idx;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          // The RAM reads word 0 on this edge, so its data and valid emerge together.
          if (lat_cnt == '0) begin
            state      <= BURST;
            beat       <= beat + 1'b1;
            valid_q    <= 1'b1;
            burstlen_q <= BURST_LEN_VAL;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        BURST: begin
          valid_q    <= 1'b1;
          burstlen_q <= BURST_LEN_VAL;
          beat       <= beat + 1'b1;
          if (beat == LAST_BEAT) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        WACK: begin
          valid_q    <= 1'b1;
          burstlen_q <= WACK_LEN_VAL;
          state      <= IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  mem_burst_ram #(
    .DATABITS (DATABITS),
    .AW       (MEMWORDS_LOG2)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.mem_datain),
    .rdata (ram_rdata)
  );

  assign bus.mem_out      = ram_rdata;
  assign bus.mem_valid    = valid_q;
  assign bus.mem_burstlen = burstlen_q;
  assign bus.mem_busy     = busy_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Randomized bench for mem_burst_responder against an array-level reference model.
// Each operation checks cycle-exact valid/busy/burstlen/data from the request edge.
// Honours MEM_WRAP_BURST_EN for the expected word order.
module tb_mem_burst_responder;

  localparam int L     = 4;
  localparam int B     = 32;
  localparam int MW    = 10;
  localparam int DEPTH = 1 << MW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_burst_responder_if #(.ADDRBITS(32), .DATABITS(32)) bus ();

  mem_burst_responder #(
    .ADDRBITS      (32),
    .DATABITS      (32),
    .MEMWORDS_LOG2 (MW),
    .BURSTLEN      (B),
    .LATENCY       (L)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_out;
  logic [31:0] last_burst [B];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_rdreq = 1'b0;
    bus.mem_wrreq = 1'b0;
  endtask

  // Expected word i of a burst, taken straight from the addressing rules.
  function automatic logic [31:0] burst_word(input logic [31:0] addr, input int i);
    int w;
    int base;
    int off;
    w    = int'(addr[MW+1:2]);
    base = w - (w % B);
`ifdef MEM_WRAP_BURST_EN
    off = (w + i) % B;
`else
    off = i;
`endif
    return ref_mem[(base + off) % DEPTH];
  endfunction

  task automatic gap(input int n);
    idle_inputs();
    for (int g = 0; g < n; g++) begin
      tick();
      chk("gap_vld", 32'(bus.mem_valid), 32'd0);
      chk("gap_len", 32'(bus.mem_burstlen), 32'd0);
      chk("gap_hold", bus.mem_out, last_out);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    bus.mem_addr   = addr;
    bus.mem_datain = data;
    bus.mem_wrreq  = 1'b1;
    bus.mem_rdreq  = 1'b0;
    tick();
    idle_inputs();
    bus.mem_addr   = $urandom;
    bus.mem_datain = $urandom;
    ref_mem[addr[MW+1:2]] = data;
    chk("wr_hold", bus.mem_out, last_out);
    chk("wr_vld0", 32'(bus.mem_valid), 32'd0);
    chk("wr_busy", 32'(bus.mem_busy), 32'd1);
    tick();
    chk("wr_ack_vld", 32'(bus.mem_valid), 32'd1);
    chk("wr_ack_len", 32'(bus.mem_burstlen), 32'd1);
    chk("wr_ack_dat", bus.mem_out, data);
    chk("wr_ack_busy", 32'(bus.mem_busy), 32'd0);
    last_out = data;
  endtask

  // Read burst. Ends right after the last word so that a following request is back-to-back.
  task automatic do_read(input logic [31:0] addr, input bit with_wr, input logic [31:0] wdat,
                         input bit poke, input bit abort);
    logic [31:0] exp_w [B];
    bit exp_v;
    for (int i = 0; i < B; i++) exp_w[i] = burst_word(addr, i);
    bus.mem_addr   = addr;
    bus.mem_rdreq  = 1'b1;
    bus.mem_wrreq  = with_wr;
    bus.mem_datain = wdat;
    tick();
    idle_inputs();
    for (int j = 0; j < L + B; j++) begin
      exp_v = (j >= L);
      if (j == 0) chk("rd_hold", bus.mem_out, last_out);
      chk("rd_vld", 32'(bus.mem_valid), 32'(exp_v));
      chk("rd_len", 32'(bus.mem_burstlen), exp_v ? 32'(B) : 32'd0);
      chk("rd_busy", 32'(bus.mem_busy), (j < L + B - 1) ? 32'd1 : 32'd0);
      if (exp_v) begin
        chk("rd_dat", bus.mem_out, exp_w[j-L]);
        last_burst[j-L] = bus.mem_out;
      end
      if (abort && j == L + 9) begin
        idle_inputs();
        reset = 1'b1;
        tick();
        chk("rst_vld", 32'(bus.mem_valid), 32'd0);
        chk("rst_len", 32'(bus.mem_burstlen), 32'd0);
        chk("rst_busy", 32'(bus.mem_busy), 32'd0);
        chk("rst_out", bus.mem_out, 32'd0);
        reset = 1'b0;
        last_out = 32'd0;
        return;
      end
      if (j < L + B - 1) begin
        if (poke) begin
          bus.mem_rdreq  = 1'($urandom_range(0, 1));
          bus.mem_wrreq  = 1'($urandom_range(0, 1));
          bus.mem_addr   = $urandom;
          bus.mem_datain = $urandom;
        end
        tick();
      end
    end
    idle_inputs();
    last_out = exp_w[B-1];
  endtask

  initial begin
    bus.mem_addr   = '0;
    bus.mem_datain = '0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_vld", 32'(bus.mem_valid), 32'd0);
    chk("reset_len", 32'(bus.mem_burstlen), 32'd0);
    chk("reset_busy", 32'(bus.mem_busy), 32'd0);
    chk("reset_out", bus.mem_out, 32'd0);
    reset = 1'b0;
    last_out = 32'd0;

    // Preload array[i] = i through the write path.
    for (int i = 0; i < DEPTH; i++) do_write(32'(i * 4), 32'(i));

    // Read line 1 from word 0x21.
    do_read(32'h84, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef MEM_WRAP_BURST_EN
    chk("plan84_first", last_burst[0], 32'h21);
    chk("plan84_last", last_burst[B-1], 32'h20);
`else
    chk("plan84_first", last_burst[0], 32'h20);
    chk("plan84_last", last_burst[B-1], 32'h3F);
`endif

    // Write then read it back through a burst.
    gap(1);
    do_write(32'h10, 32'hDEADBEEF);
    do_read(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("plan_wb_w4", last_burst[4], 32'hDEADBEEF);

    // Simultaneous read and write: the read wins and the write is dropped.
    do_read(32'h0, 1'b1, 32'h55, 1'b0, 1'b0);
    do_read(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("plan_rdwr_w0", last_burst[0], 32'h0);

    // Requests while busy are ignored.
    do_read(32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
    gap(2);

    // Reset in the middle of a burst, then a normal burst.
    do_read(32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
    gap(3);
    do_read(32'h104, 1'b0, 32'h0, 1'b0, 1'b0);

    // Top line of the array.
    do_read(32'hF80, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("plan_top_last", last_burst[B-1], 32'h3FF);

    // Random mix of reads, writes, collisions, pokes and gaps.
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 4) begin
        do_write($urandom, $urandom);
      end else begin
        do_read($urandom, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end
      if ($urandom_range(0, 2) == 0) gap(int'($urandom_range(1, 3)));
    end

    do_read(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
